// File: rtl/circle_decode_fsm_32bit_if.sv
// Request/response bundle for the circle point decoder: point and base in,
// angle, recovered index and status out.
interface circle_decode_fsm_32bit_if;
   logic        start;
   logic [31:0] x_in;
   logic [31:0] y_in;
   logic [1:0]  base_sel;
   logic [15:0] angle_out;
   logic [31:0] k_out;
   logic        err;
   logic        done;
   logic        ready;

   modport master (output start, x_in, y_in, base_sel,
                   input  angle_out, k_out, err, done, ready);
   modport slave  (input  start, x_in, y_in, base_sel,
                   output angle_out, k_out, err, done, ready);
endinterface

// File: rtl/circle_decode_fsm_32bit.sv
// Decodes a unit-circle point back to its angle (CORDIC vectoring, 16 steps)
// and to the Van der Corput index by re-extracting radical-inverse digits.
module circle_decode_fsm_32bit (
   input  logic                      clk,
   input  logic                      rst_n,
   circle_decode_fsm_32bit_if.slave  bus
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_VEC, S_RND, S_DIG, S_FIN} state_t;

   state_t             state_q, state_d;
   logic signed [33:0] x_q, y_q;
   logic [15:0]        z_q, f_q, w_q, ang_q;
   logic [3:0]         cnt_q;
   logic [1:0]         bsel_q;
   logic [31:0]        k_q, kout_q;
   logic               err_calc_q, err_q, done_q, ready_q;

   logic ld, pre, vec, rnd, dig, fin;

   // Per-base radix, last digit index (D-1) and half-grid rounding offset.
   logic [2:0]  b;
   logic [3:0]  dlast;
   logic [15:0] roff;
   always_comb begin
      b = 3'd2; dlast = 4'd11; roff = 16'd8;
      unique case (bsel_q)
         2'b01:   begin b = 3'd3; dlast = 4'd7; roff = 16'd5;  end
         2'b10:   begin b = 3'd7; dlast = 4'd3; roff = 16'd14; end
         default: begin b = 3'd2; dlast = 4'd11; roff = 16'd8; end
      endcase
   end

   function automatic logic [15:0] atan_t(input logic [3:0] i);
      unique case (i)
         4'd0:  return 16'd8192;
         4'd1:  return 16'd4836;
         4'd2:  return 16'd2555;
         4'd3:  return 16'd1297;
         4'd4:  return 16'd651;
         4'd5:  return 16'd326;
         4'd6:  return 16'd163;
         4'd7:  return 16'd81;
         4'd8:  return 16'd41;
         4'd9:  return 16'd20;
         4'd10: return 16'd10;
         4'd11: return 16'd5;
         4'd12: return 16'd3;
         4'd13: return 16'd1;
         4'd14: return 16'd1;
         default: return 16'd0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (bus.start && ready_q) state_d = S_PRE;
         S_PRE:  state_d = S_VEC;
         S_VEC:  if (cnt_q == 4'd15) state_d = S_RND;
         S_RND:  state_d = S_DIG;
         S_DIG:  if (cnt_q == dlast) state_d = S_FIN;
         S_FIN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ld = 1'b0; pre = 1'b0; vec = 1'b0; rnd = 1'b0; dig = 1'b0; fin = 1'b0;
      unique case (state_q)
         S_IDLE: ld  = bus.start && ready_q;
         S_PRE:  pre = 1'b1;
         S_VEC:  vec = 1'b1;
         S_RND:  rnd = 1'b1;
         S_DIG:  dig = 1'b1;
         S_FIN:  fin = 1'b1;
         default: ;
      endcase
   end

   logic signed [33:0] xs, ys;
   logic [18:0]        p;
   logic [31:0]        dw;
   assign xs = x_q >>> cnt_q;
   assign ys = y_q >>> cnt_q;
   assign p  = 19'(f_q) * 19'(b);
   assign dw = 32'(p[18:16]) * 32'(w_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0; y_q <= '0; z_q <= '0; f_q <= '0; w_q <= '0;
         cnt_q <= '0; bsel_q <= '0; k_q <= '0; err_calc_q <= 1'b0;
         ang_q <= '0; kout_q <= '0; err_q <= 1'b0;
         done_q <= 1'b0; ready_q <= 1'b1;
      end else begin
         done_q <= fin;
         if (ld)                      ready_q <= 1'b0;
         else if (state_q == S_IDLE)  ready_q <= 1'b1;
         if (ld) begin
            x_q    <= {{2{bus.x_in[31]}}, bus.x_in};
            y_q    <= {{2{bus.y_in[31]}}, bus.y_in};
            bsel_q <= bus.base_sel;
         end
         if (pre) begin
            // Left half-plane: rotate by half a turn so vectoring converges.
            if (x_q[33]) begin
               x_q <= -x_q; y_q <= -y_q; z_q <= 16'h8000;
            end else begin
               z_q <= 16'h0000;
            end
            err_calc_q <= (x_q == '0) && (y_q == '0);
            cnt_q      <= '0;
         end
         if (vec) begin
            if (!y_q[33]) begin
               x_q <= x_q + ys; y_q <= y_q - xs; z_q <= z_q + atan_t(cnt_q);
            end else begin
               x_q <= x_q - ys; y_q <= y_q + xs; z_q <= z_q - atan_t(cnt_q);
            end
            cnt_q <= cnt_q + 4'd1;
         end
         if (rnd) begin
            f_q <= z_q + roff; k_q <= '0; w_q <= 16'd1; cnt_q <= '0;
         end
         if (dig) begin
            f_q   <= p[15:0];
            k_q   <= k_q + dw;
            w_q   <= w_q * 16'(b);
            cnt_q <= cnt_q + 4'd1;
         end
         // All results are published together so they stay coherent until the next FIN.
         if (fin) begin
            ang_q <= z_q; kout_q <= k_q; err_q <= err_calc_q;
         end
      end
   end

   assign bus.angle_out = ang_q;
   assign bus.k_out     = kout_q;
   assign bus.err       = err_q;
   assign bus.done      = done_q;
   assign bus.ready     = ready_q;

endmodule

// File: tb/tb_circle_decode_fsm_32bit.sv
// Bench for circle_decode_fsm_32bit: directed table, control sequences and
// randomized round trips against a real-arithmetic reference.
module tb_circle_decode_fsm_32bit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   circle_decode_fsm_32bit_if bus();
   circle_decode_fsm_32bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk = 0;
   int n_pass = 0;
   localparam real TWO_PI = 6.283185307179586;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [1:0]  s;
      int          ang;   // -1: angle not checked
      int          k;
      bit          e;
      bit          ck;
   } vec_t;

   task automatic check(input string name, input bit ok, input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   function automatic int base_of(input logic [1:0] s);
      return (s == 2'b01) ? 3 : (s == 2'b10) ? 7 : 2;
   endfunction
   function automatic int digs_of(input logic [1:0] s);
      return (s == 2'b01) ? 8 : (s == 2'b10) ? 4 : 12;
   endfunction
   function automatic int ipow(input int b, input int d);
      int r = 1;
      repeat (d) r *= b;
      return r;
   endfunction
   function automatic real vdc(input int k, input int b);
      real r = 0.0;
      real w = 1.0 / b;
      int  kk = k;
      while (kk > 0) begin
         r += (kk % b) * w;
         kk /= b;
         w /= b;
      end
      return r;
   endfunction
   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction
   function automatic int adiff(input int a, input int b);
      int d = (a - b) & 32'hFFFF;
      if (d > 32767) d -= 65536;
      return (d < 0) ? -d : d;
   endfunction
   function automatic int ideal_ang(input logic [31:0] x, input logic [31:0] y);
      real a = $atan2(real'($signed(y)), real'($signed(x)));
      if (a < 0.0) a += TWO_PI;
      return rnd(a / TWO_PI * 65536.0) & 32'hFFFF;
   endfunction

   task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [1:0] s,
                      output int ang, output int k, output bit e, output int lat);
      int g = 0;
      @(negedge clk);
      while (!bus.ready && g < 200) begin @(negedge clk); g++; end
      bus.x_in = x; bus.y_in = y; bus.base_sel = s; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      lat = 1;
      while (lat < 100) begin
         @(negedge clk);
         if (bus.done) break;
         @(posedge clk); lat++;
      end
      ang = int'(bus.angle_out); k = int'(bus.k_out); e = bus.err;
   endtask

   vec_t tv[10];

   initial begin
      int ang, k, lat, nd, t, tp, kk, kexp, n, d, sc_i;
      bit e;
      logic [1:0] s;
      logic [31:0] xr, yr;
      real th, sc;

      tv[0] = '{32'h00010000, 32'h00000000, 2'd0, 0,     0, 1'b0, 1'b1};
      tv[1] = '{32'h00000000, 32'h00010000, 2'd0, 16384, 2, 1'b0, 1'b1};
      tv[2] = '{32'hFFFF0000, 32'h00000000, 2'd0, 32768, 1, 1'b0, 1'b1};
      tv[3] = '{32'h00000000, 32'hFFFF0000, 2'd0, 49152, 3, 1'b0, 1'b1};
      tv[4] = '{32'hFFFF8000, 32'h0000DDB4, 2'd1, 21845, 1, 1'b0, 1'b1};
      tv[5] = '{32'hFFFF8000, 32'hFFFF224C, 2'd1, 43691, 2, 1'b0, 1'b1};
      tv[6] = '{32'h80000000, 32'h00000000, 2'd0, 32768, 1, 1'b0, 1'b1};
      tv[7] = '{32'h00000000, 32'h00010000, 2'd3, 16384, 2, 1'b0, 1'b1};
      tv[8] = '{32'h00000000, 32'h00000000, 2'd0, -1,    0, 1'b1, 1'b0};
      tv[9] = '{32'h00009F9D, 32'h0000C826, 2'd2, 9362,  1, 1'b0, 1'b1};

      bus.start = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.base_sel = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", bus.ready == 1'b1, bus.ready, 1);
      check("rst_done",  bus.done == 1'b0, bus.done, 0);
      check("rst_err",   bus.err == 1'b0, bus.err, 0);
      check("rst_k",     bus.k_out == 32'd0, bus.k_out, 0);
      check("rst_angle", bus.angle_out == 16'd0, bus.angle_out, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run(tv[i].x, tv[i].y, tv[i].s, ang, k, e, lat);
         check($sformatf("vec%0d_latency", i), lat == 20 + digs_of(tv[i].s), lat, 20 + digs_of(tv[i].s));
         check($sformatf("vec%0d_err", i), e == tv[i].e, e, tv[i].e);
         if (tv[i].ang >= 0)
            check($sformatf("vec%0d_angle", i), adiff(ang, tv[i].ang) <= 2, ang, tv[i].ang);
         if (tv[i].ck)
            check($sformatf("vec%0d_k", i), k == tv[i].k, k, tv[i].k);
      end

      // start while busy must not launch a second request
      @(negedge clk);
      bus.x_in = 32'h0; bus.y_in = 32'h00010000; bus.base_sel = 2'd0; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (5) @(negedge clk);
      bus.x_in = 32'hFFFF0000; bus.y_in = 32'h0; bus.base_sel = 2'd2; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      nd = 0; ang = 0; k = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.done) begin nd++; ang = int'(bus.angle_out); k = int'(bus.k_out); end
      end
      check("busy_done_count", nd == 1, nd, 1);
      check("busy_k", k == 2, k, 2);
      check("busy_angle", adiff(ang, 16384) <= 2, ang, 16384);

      // abort in the middle of vectoring
      @(negedge clk);
      bus.x_in = 32'hFFFF0000; bus.y_in = 32'h0; bus.base_sel = 2'd0; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (11) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_ready", bus.ready == 1'b1, bus.ready, 1);
      check("abort_done",  bus.done == 1'b0, bus.done, 0);
      check("abort_k",     bus.k_out == 32'd0, bus.k_out, 0);
      check("abort_angle", bus.angle_out == 16'd0, bus.angle_out, 0);
      check("abort_err",   bus.err == 1'b0, bus.err, 0);
      @(negedge clk); rst_n = 1'b1;
      nd = 0;
      repeat (40) begin @(negedge clk); if (bus.done) nd++; end
      check("abort_no_done", nd == 0, nd, 0);
      run(32'hFFFF0000, 32'h0, 2'd0, ang, k, e, lat);
      check("after_abort_k", k == 1, k, 1);
      check("after_abort_latency", lat == 32, lat, 32);

      // back-to-back with start held high
      for (int j = 0; j < 2; j++) begin
         s = (j == 0) ? 2'd2 : 2'd1;
         d = digs_of(s);
         @(negedge clk);
         bus.x_in = 32'h00010000; bus.y_in = 32'h0; bus.base_sel = s; bus.start = 1'b1;
         t = 0; nd = 0; tp = 0;
         while (t < 200 && nd < 3) begin
            @(negedge clk); t++;
            if (bus.done) begin
               if (nd > 0) check($sformatf("b2b_spacing_b%0d", base_of(s)), t - tp == 21 + d, t - tp, 21 + d);
               tp = t; nd++;
            end
         end
         bus.start = 1'b0;
         check($sformatf("b2b_count_b%0d", base_of(s)), nd == 3, nd, 3);
      end

      // randomized round trips: generator point of index k must decode to k
      for (int i = 0; i < 120; i++) begin
         s = 2'($urandom_range(0, 3));
         n = ipow(base_of(s), digs_of(s));
         kk = (i < 4) ? ((i % 2 == 0) ? n - 1 : 0) : int'($urandom_range(0, n - 1));
         sc_i = int'($urandom_range(0, 3));
         sc = (sc_i == 0) ? 1.0 : (sc_i == 1) ? 0.5 : (sc_i == 2) ? 37.25 : 20000.0;
         th = TWO_PI * vdc(kk, base_of(s));
         xr = 32'(rnd(sc * 65536.0 * $cos(th)));
         yr = 32'(rnd(sc * 65536.0 * $sin(th)));
         kexp = kk;
         run(xr, yr, s, ang, k, e, lat);
         check($sformatf("rt%0d_k b=%0d", i, base_of(s)), k == kexp, k, kexp);
         check($sformatf("rt%0d_angle", i), adiff(ang, rnd(vdc(kk, base_of(s)) * 65536.0) & 32'hFFFF) <= 4,
               ang, rnd(vdc(kk, base_of(s)) * 65536.0) & 32'hFFFF);
         check($sformatf("rt%0d_latency", i), lat == 20 + digs_of(s), lat, 20 + digs_of(s));
      end

      // arbitrary full-range points: angle against real atan2
      for (int i = 0; i < 60; i++) begin
         xr = $urandom; yr = $urandom;
         s = 2'($urandom_range(0, 3));
         run(xr, yr, s, ang, k, e, lat);
         check($sformatf("rnd%0d_angle", i), adiff(ang, ideal_ang(xr, yr)) <= 4, ang, ideal_ang(xr, yr));
         check($sformatf("rnd%0d_err", i), e == 1'b0, e, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
